pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined successor to the combinational reverser-based barrel shifter.
- Supports logical, arithmetic and rotate shifts in both directions, with one register stage per shift bit and a valid/ready handshake on input and output.
- Sits between operand sources and the ALU/datapath result mux. Sustains one operation per cycle when not back-pressured.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 23 ++
 rtl/pipelined_barrel_shifter_shift_stage.sv | 64 ++++++
 rtl/pipelined_barrel_shifter.sv | 93 +++++++++
 tb/tb_pipelined_barrel_shifter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
//   shift_op_t : operation encoding carried down the pipe
//   DIR_LEFT / DIR_RIGHT : encoding of the in_lr direction bit
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_LOGICAL = 2'd0,
        SHIFT_ARITH   = 2'd1,
        SHIFT_ROTATE  = 2'd2,
        SHIFT_RSVD    = 2'd3
    } shift_op_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Vacated-MSB fill value chosen at entry: only an arithmetic right shift
    // replicates the sign; everything else (including reserved op) fills 0.
    function automatic logic entry_fill(input shift_op_t op, input logic lr,
                                        input logic msb);
        return (op == SHIFT_ARITH) && (lr == DIR_RIGHT) && msb;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One pipeline stage of the barrel shifter: conditional right shift (or
// rotate) by 2**K, selected by amt bit K, registered together with the
// operation's sideband.
//   clk, rst_n (sync, active-low), stall (hold all registers)
//   in_*  : stage input  (valid, data, amt, op, lr, fill)
//   out_* : registered stage output, same fields
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned K  = 0,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  shift_op_t     in_op,
    input  logic          in_lr,
    input  logic          in_fill,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] out_amt,
    output shift_op_t     out_op,
    output logic          out_lr,
    output logic          out_fill
);

    localparam int unsigned S = 2 ** K;

    logic [W-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_amt[K]) begin
            if (in_op == SHIFT_ROTATE) begin
                shifted = {in_data[S-1:0], in_data[W-1:S]};
            end else begin
                shifted = {{S{in_fill}}, in_data[W-1:S]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_op    <= SHIFT_LOGICAL;
            out_lr    <= 1'b0;
            out_fill  <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_amt   <= in_amt;
            out_op    <= in_op;
            out_lr    <= in_lr;
            out_fill  <= in_fill;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: logical / arithmetic / rotate, left or right,
// one register stage per shift-amount bit, valid/ready on both sides.
// Left shifts run as right shifts on bit-reversed data.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake; in_data, in_amt, in_lr, in_op
//   out_valid/out_ready   : output handshake; out_data
//   out_zero              : result-is-zero flag, present only when
//                           PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN is defined
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] in_data,
    input  logic [N-1:0]    in_amt,
    input  logic            in_lr,
    input  logic [1:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    output logic            out_zero,
`endif
    output logic [2**N-1:0] out_data
);

    localparam int unsigned W = 2 ** N;

    logic         stall;
    logic [W-1:0] in_rev;
    logic [W-1:0] res_rev;

    // Index 0 is the entry point; index k+1 is the output of stage k.
    logic         valid_q [0:N];
    logic [W-1:0] data_q  [0:N];
    logic [N-1:0] amt_q   [0:N];
    shift_op_t    op_q    [0:N];
    logic         lr_q    [0:N];
    logic         fill_q  [0:N];

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[N];

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign in_rev[i]  = in_data[W-1-i];
        assign res_rev[i] = data_q[N][W-1-i];
    end

    // Stage 0 ignores its input while stalled, so in_valid needs no gating.
    assign valid_q[0] = in_valid;
    assign data_q[0]  = (in_lr == DIR_LEFT) ? in_rev : in_data;
    assign amt_q[0]   = in_amt;
    assign op_q[0]    = shift_op_t'(in_op);
    assign lr_q[0]    = in_lr;
    assign fill_q[0]  = entry_fill(shift_op_t'(in_op), in_lr, in_data[W-1]);

    for (genvar k = 0; k < N; k++) begin : g_stage
        shift_stage #(
            .W  (W),
            .K  (k),
            .AW (N)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .stall     (stall),
            .in_valid  (valid_q[k]),
            .in_data   (data_q[k]),
            .in_amt    (amt_q[k]),
            .in_op     (op_q[k]),
            .in_lr     (lr_q[k]),
            .in_fill   (fill_q[k]),
            .out_valid (valid_q[k+1]),
            .out_data  (data_q[k+1]),
            .out_amt   (amt_q[k+1]),
            .out_op    (op_q[k+1]),
            .out_lr    (lr_q[k+1]),
            .out_fill  (fill_q[k+1])
        );
    end

    assign out_data = (lr_q[N] == DIR_LEFT) ? res_rev : data_q[N];

`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    // Derived from the final-stage registers only, so it holds with them
    // during a stall; gated by valid so the reset value is 0.
    assign out_zero = valid_q[N] && (data_q[N] == '0);
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

    localparam int unsigned N = 3;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [N-1:0] in_amt;
    logic         in_lr;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    logic         out_zero;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_lr     (in_lr),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic lr,
                         input logic [2:0] amt, input logic [7:0] d);
        in_valid = v;
        in_op    = op;
        in_lr    = lr;
        in_amt   = amt;
        in_data  = d;
    endtask

    // Single isolated operation: accepted at the edge after the drive,
    // result must be visible N cycles after the acceptance cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic lr, input logic [2:0] amt,
                          input logic [7:0] d, input logic [7:0] exp);
        @(negedge clk);
        drive(1'b1, op, lr, amt, d);
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 3'd0, 8'h00);
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_lat2"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
        check({tag, "_zero"}, out_zero, (exp == 8'h00));
`endif
    endtask

    logic [7:0] e;
    logic [7:0] bp_exp [0:3];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 3'd0, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ready", in_ready, 1);
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
        check("rst_zero", out_zero, 0);
`endif

        // Directed operations (op: 0 SRL/SLL, 1 arith, 2 rotate, 3 reserved)
        run_op("sra2",   2'd1, 1'b1, 3'd2, 8'h96, 8'hE5);
        run_op("srl2",   2'd0, 1'b1, 3'd2, 8'h96, 8'h25);
        run_op("sll3",   2'd0, 1'b0, 3'd3, 8'h96, 8'hB0);
        run_op("ror3",   2'd2, 1'b1, 3'd3, 8'h96, 8'hD2);
        run_op("rol1",   2'd2, 1'b0, 3'd1, 8'h96, 8'h2D);
        run_op("rsvd1",  2'd3, 1'b1, 3'd1, 8'h96, 8'h4B);
        run_op("sla1",   2'd1, 1'b0, 3'd1, 8'h96, 8'h2C);
        run_op("sra0",   2'd1, 1'b1, 3'd0, 8'h96, 8'h96);
        run_op("rol0",   2'd2, 1'b0, 3'd0, 8'h96, 8'h96);
        run_op("sra7",   2'd1, 1'b1, 3'd7, 8'h96, 8'hFF);
        run_op("sll7",   2'd0, 1'b0, 3'd7, 8'h96, 8'h00);
        run_op("rol7",   2'd2, 1'b0, 3'd7, 8'h96, 8'h4B);
        run_op("srl1z",  2'd0, 1'b1, 3'd1, 8'h01, 8'h00);
        run_op("ror1nz", 2'd2, 1'b1, 3'd1, 8'h01, 8'h80);

        // Back-to-back ROL of 0x01 by 0..7
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) drive(1'b1, 2'd2, 1'b0, 3'(c), 8'h01);
            else       drive(1'b0, 2'd0, 1'b0, 3'd0, 8'h00);
            #1;
            if (c < 8) check($sformatf("strm_rdy%0d", c), in_ready, 1);
            if (c >= 3 && c < 11) begin
                e = 8'h01 << (c - 3);
                check($sformatf("strm_vld%0d", c), out_valid, 1);
                check($sformatf("strm_data%0d", c), out_data, e);
            end else begin
                check($sformatf("strm_idle%0d", c), out_valid, 0);
            end
        end

        // Backpressure: fill the pipe with out_ready low, hold 5 stalled cycles
        bp_exp[0] = 8'h22;
        bp_exp[1] = 8'h10;
        bp_exp[2] = 8'hFF;
        bp_exp[3] = 8'h0F;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 1'b0, 3'd1, 8'h11);
        #1 check("bp_rdy0", in_ready, 1);
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b1, 3'd4, 8'h01);
        #1 check("bp_rdy1", in_ready, 1);
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b1, 3'd7, 8'h80);
        #1 check("bp_rdy2", in_ready, 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            drive(1'b1, 2'd0, 1'b1, 3'd4, 8'hF0);
            #1;
            check($sformatf("bp_stall_rdy%0d", s), in_ready, 0);
            check($sformatf("bp_stall_vld%0d", s), out_valid, 1);
            check($sformatf("bp_stall_data%0d", s), out_data, bp_exp[0]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", in_ready, 1);
        check("bp_rel_vld", out_valid, 1);
        check("bp_rel_data", out_data, bp_exp[0]);
        for (int r = 1; r < 4; r++) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 1'b0, 3'd0, 8'h00);
            #1;
            check($sformatf("bp_out_vld%0d", r), out_valid, 1);
            check($sformatf("bp_out_data%0d", r), out_data, bp_exp[r]);
        end
        @(negedge clk);
        #1 check("bp_drained", out_valid, 0);

        // Reset with three operations in flight
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b1, 3'd0, 8'hA5);
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 3'd3, 8'h3C);
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b1, 3'd1, 8'hF1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 3'd0, 8'h00);
        #1;
        check("mrst_vld", out_valid, 0);
        check("mrst_data", out_data, 0);
        check("mrst_rdy", in_ready, 1);
        for (int q = 0; q < 4; q++) begin
            @(negedge clk);
            #1 check($sformatf("mrst_nostale%0d", q), out_valid, 0);
        end
        run_op("post_rst", 2'd0, 1'b0, 3'd4, 8'h0F, 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
